// File: rtl/hazard_syscall_ctrl.sv
// Decode-stage sequencing: load-use hazard detection against a shift-register
// scoreboard of in-flight loads, plus the syscall freeze/drain/signal/resume FSM.
module hazard_syscall_ctrl #(
  parameter int LOAD_LAT     = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       Valid_IN,
  input  logic [4:0] ReadRegA_IN,
  input  logic [4:0] ReadRegB_IN,
  input  logic       UsesA_IN,
  input  logic       UsesB_IN,
  input  logic [4:0] WriteReg_IN,
  input  logic       RegWrite_IN,
  input  logic       MemRead_IN,
  input  logic       Syscall_IN,
  input  logic       Ext_Stall_IN,
  output logic       Stall_OUT,
  output logic       Bubble_OUT,
  output logic       SYS_OUT,
  output logic       Busy_OUT,
  output logic [1:0] State_OUT
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SIGNAL = 2'd2,
    RESUME = 2'd3
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [LOAD_LAT-1:0] sb_valid_q;
  logic [LOAD_LAT-1:0] sb_valid_d;
  logic [LOAD_LAT-1:0] sb_hit;
  logic [4:0]          sb_reg_q [LOAD_LAT];
  logic [4:0]          sb_reg_d [LOAD_LAT];

  logic hazard;
  logic issue;
  logic stall_c;
  logic bubble_c;
  logic sys_c;

  // Entry 0 is the youngest load; older entries shift toward the tail.
  generate
    for (genvar gi = 0; gi < LOAD_LAT; gi++) begin : g_sb
      assign sb_hit[gi] = sb_valid_q[gi] && (sb_reg_q[gi] != 5'd0) &&
                          ((UsesA_IN && (sb_reg_q[gi] == ReadRegA_IN)) ||
                           (UsesB_IN && (sb_reg_q[gi] == ReadRegB_IN)));
      if (gi == 0) begin : g_head
        assign sb_valid_d[gi] = issue && MemRead_IN && RegWrite_IN && (WriteReg_IN != 5'd0);
        assign sb_reg_d[gi]   = WriteReg_IN;
      end else begin : g_tail
        assign sb_valid_d[gi] = sb_valid_q[gi-1];
        assign sb_reg_d[gi]   = sb_reg_q[gi-1];
      end
    end
  endgenerate

  assign hazard = Valid_IN && (|sb_hit);
  assign issue  = Valid_IN && !stall_c && !Ext_Stall_IN;

  always_comb begin
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    sys_c    = 1'b0;
    if (Ext_Stall_IN) begin
      stall_c = 1'b1;
    end else if (state_q == IDLE) begin
      stall_c  = hazard;
      bubble_c = hazard;
    end else begin
      stall_c  = 1'b1;
      bubble_c = 1'b1;
      sys_c    = (state_q == SIGNAL);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sb_valid_q <= '0;
      for (int i = 0; i < LOAD_LAT; i++) sb_reg_q[i] <= 5'd0;
    end else if (!Ext_Stall_IN) begin
      sb_valid_q <= sb_valid_d;
      for (int i = 0; i < LOAD_LAT; i++) sb_reg_q[i] <= sb_reg_d[i];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (!Ext_Stall_IN) begin
      case (state_q)
        IDLE: begin
          // A dependent syscall waits here until its source load retires.
          if (Valid_IN && Syscall_IN && !hazard) begin
            state_q <= DRAIN;
            cnt_q   <= CW'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (cnt_q == CW'(1)) begin
            state_q <= SIGNAL;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        SIGNAL:  state_q <= RESUME;
        RESUME:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gate with RESET so Ext_Stall_IN cannot leak a stall while in reset.
  assign Stall_OUT  = RESET && stall_c;
  assign Bubble_OUT = RESET && bubble_c;
  assign SYS_OUT    = RESET && sys_c;
  assign Busy_OUT   = (state_q != IDLE);
  assign State_OUT  = state_q;

endmodule

// File: tb/tb_hazard_syscall_ctrl.sv
// Directed bench for hazard_syscall_ctrl: expectations are queued as each cycle's
// stimulus is driven and popped for comparison once the outputs have settled.
module tb_hazard_syscall_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       Valid_IN;
  logic [4:0] ReadRegA_IN;
  logic [4:0] ReadRegB_IN;
  logic       UsesA_IN;
  logic       UsesB_IN;
  logic [4:0] WriteReg_IN;
  logic       RegWrite_IN;
  logic       MemRead_IN;
  logic       Syscall_IN;
  logic       Ext_Stall_IN;
  logic       Stall_OUT;
  logic       Bubble_OUT;
  logic       SYS_OUT;
  logic       Busy_OUT;
  logic [1:0] State_OUT;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic       stall;
    logic       bubble;
    logic       sys;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];

  hazard_syscall_ctrl #(.LOAD_LAT(2), .DRAIN_CYCLES(3)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .Valid_IN     (Valid_IN),
    .ReadRegA_IN  (ReadRegA_IN),
    .ReadRegB_IN  (ReadRegB_IN),
    .UsesA_IN     (UsesA_IN),
    .UsesB_IN     (UsesB_IN),
    .WriteReg_IN  (WriteReg_IN),
    .RegWrite_IN  (RegWrite_IN),
    .MemRead_IN   (MemRead_IN),
    .Syscall_IN   (Syscall_IN),
    .Ext_Stall_IN (Ext_Stall_IN),
    .Stall_OUT    (Stall_OUT),
    .Bubble_OUT   (Bubble_OUT),
    .SYS_OUT      (SYS_OUT),
    .Busy_OUT     (Busy_OUT),
    .State_OUT    (State_OUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic ins(input logic v, input logic [4:0] ra, input logic ua,
                     input logic [4:0] rb, input logic ub, input logic [4:0] wr,
                     input logic rw, input logic mr, input logic sc);
    Valid_IN    = v;
    ReadRegA_IN = ra;
    UsesA_IN    = ua;
    ReadRegB_IN = rb;
    UsesB_IN    = ub;
    WriteReg_IN = wr;
    RegWrite_IN = rw;
    MemRead_IN  = mr;
    Syscall_IN  = sc;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string tag, input logic s, input logic b,
                      input logic y, input logic [1:0] st);
    exp_t e;
    e.tag = tag; e.stall = s; e.bubble = b; e.sys = y; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic exp_busy;
    e = exp_q.pop_front();
    exp_busy = (e.st != 2'd0);
    checks++;
    assert (Stall_OUT === e.stall) else begin
      failures++;
      $error("FAIL %s stall got=%0b exp=%0b", e.tag, Stall_OUT, e.stall);
    end
    checks++;
    assert (Bubble_OUT === e.bubble) else begin
      failures++;
      $error("FAIL %s bubble got=%0b exp=%0b", e.tag, Bubble_OUT, e.bubble);
    end
    checks++;
    assert (SYS_OUT === e.sys) else begin
      failures++;
      $error("FAIL %s sys got=%0b exp=%0b", e.tag, SYS_OUT, e.sys);
    end
    checks++;
    assert (Busy_OUT === exp_busy) else begin
      failures++;
      $error("FAIL %s busy got=%0b exp=%0b", e.tag, Busy_OUT, exp_busy);
    end
    checks++;
    assert (State_OUT === e.st) else begin
      failures++;
      $error("FAIL %s state got=%0d exp=%0d", e.tag, State_OUT, e.st);
    end
    $display("cycle %-14s stall=%0b bubble=%0b sys=%0b busy=%0b state=%0d",
             e.tag, Stall_OUT, Bubble_OUT, SYS_OUT, Busy_OUT, State_OUT);
  endtask

  // One clock of stimulus already applied; queue the expectation, check at negedge.
  task automatic expect_cyc(input string tag, input logic s, input logic b,
                            input logic y, input logic [1:0] st);
    push(tag, s, b, y, st);
    @(negedge CLK);
    pop_check();
  endtask

  task automatic expect_now(input string tag, input logic s, input logic b,
                            input logic y, input logic [1:0] st);
    push(tag, s, b, y, st);
    #1;
    pop_check();
  endtask

  initial begin
    RESET        = 1'b0;
    Ext_Stall_IN = 1'b1;
    ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    expect_now("reset_ext", 1'b0, 1'b0, 1'b0, 2'd0);
    Ext_Stall_IN = 1'b0;
    expect_now("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    next_cycle();
    next_cycle();
    RESET = 1'b1;

    // Load-use on rs: two stall cycles, then issue
    next_cycle(); ins(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0);
    expect_cyc("load_r5", 0, 0, 0, 2'd0);
    next_cycle(); ins(1, 5'd5, 1, 5'd2, 1, 5'd8, 1, 0, 0);
    expect_cyc("use_r5_h1", 1, 1, 0, 2'd0);
    next_cycle();
    expect_cyc("use_r5_h2", 1, 1, 0, 2'd0);
    next_cycle();
    expect_cyc("use_r5_issue", 0, 0, 0, 2'd0);

    // r0 never hazards
    next_cycle(); ins(1, 5'd1, 0, 5'd0, 0, 5'd0, 1, 1, 0);
    expect_cyc("load_r0", 0, 0, 0, 2'd0);
    next_cycle(); ins(1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0, 0);
    expect_cyc("use_r0", 0, 0, 0, 2'd0);

    // Independent instructions after a load; unused rt matching the load
    next_cycle(); ins(1, 5'd1, 0, 5'd0, 0, 5'd5, 1, 1, 0);
    expect_cyc("load_r5b", 0, 0, 0, 2'd0);
    next_cycle(); ins(1, 5'd6, 1, 5'd7, 1, 5'd9, 1, 0, 0);
    expect_cyc("indep1", 0, 0, 0, 2'd0);
    next_cycle(); ins(1, 5'd6, 1, 5'd5, 0, 5'd9, 1, 0, 0);
    expect_cyc("rt_unused", 0, 0, 0, 2'd0);

    // Back-to-back loads occupy consecutive entries
    next_cycle(); ins(1, 5'd1, 0, 5'd0, 0, 5'd9, 1, 1, 0);
    expect_cyc("load_r9", 0, 0, 0, 2'd0);
    next_cycle(); ins(1, 5'd1, 0, 5'd0, 0, 5'd10, 1, 1, 0);
    expect_cyc("load_r10", 0, 0, 0, 2'd0);
    next_cycle(); ins(1, 5'd9, 1, 5'd10, 1, 5'd11, 1, 0, 0);
    expect_cyc("use_9_10_h1", 1, 1, 0, 2'd0);
    next_cycle();
    expect_cyc("use_9_10_h2", 1, 1, 0, 2'd0);
    next_cycle();
    expect_cyc("use_9_10_iss", 0, 0, 0, 2'd0);

    // Scoreboard holds under external stall
    next_cycle(); ins(1, 5'd1, 0, 5'd0, 0, 5'd12, 1, 1, 0);
    expect_cyc("load_r12", 0, 0, 0, 2'd0);
    next_cycle(); ins(1, 5'd12, 1, 5'd0, 0, 5'd13, 1, 0, 0); Ext_Stall_IN = 1;
    expect_cyc("sb_ext1", 1, 0, 0, 2'd0);
    next_cycle();
    expect_cyc("sb_ext2", 1, 0, 0, 2'd0);
    next_cycle(); Ext_Stall_IN = 0;
    expect_cyc("sb_hold_h1", 1, 1, 0, 2'd0);
    next_cycle();
    expect_cyc("sb_hold_h2", 1, 1, 0, 2'd0);
    next_cycle();
    expect_cyc("sb_hold_iss", 0, 0, 0, 2'd0);

    // Plain syscall sequence
    next_cycle(); ins(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
    expect_cyc("sys_issue", 0, 0, 0, 2'd0);
    next_cycle(); ins(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0, 0);
    expect_cyc("sys_t1", 1, 1, 0, 2'd1);
    next_cycle();
    expect_cyc("sys_t2", 1, 1, 0, 2'd1);
    next_cycle();
    expect_cyc("sys_t3", 1, 1, 0, 2'd1);
    next_cycle();
    expect_cyc("sys_t4", 1, 1, 1, 2'd2);
    next_cycle();
    expect_cyc("sys_t5", 1, 1, 0, 2'd3);
    next_cycle();
    expect_cyc("sys_t6", 0, 0, 0, 2'd0);

    // Syscall dependent on a load waits, then runs; a second syscall follows
    next_cycle(); ins(1, 5'd1, 0, 5'd0, 0, 5'd4, 1, 1, 0);
    expect_cyc("load_r4", 0, 0, 0, 2'd0);
    next_cycle(); ins(1, 5'd4, 1, 5'd0, 0, 5'd0, 0, 0, 1);
    expect_cyc("sysdep_h1", 1, 1, 0, 2'd0);
    next_cycle();
    expect_cyc("sysdep_h2", 1, 1, 0, 2'd0);
    next_cycle();
    expect_cyc("sysdep_iss", 0, 0, 0, 2'd0);
    next_cycle(); ins(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
    expect_cyc("sysdep_d1", 1, 1, 0, 2'd1);
    next_cycle();
    expect_cyc("sysdep_d2", 1, 1, 0, 2'd1);
    next_cycle();
    expect_cyc("sysdep_d3", 1, 1, 0, 2'd1);
    next_cycle();
    expect_cyc("sysdep_sig", 1, 1, 1, 2'd2);
    next_cycle();
    expect_cyc("sysdep_res", 1, 1, 0, 2'd3);

    // Second syscall, with external stalls in DRAIN and in SIGNAL
    next_cycle();
    expect_cyc("sys2_issue", 0, 0, 0, 2'd0);
    next_cycle(); ins(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0, 0);
    expect_cyc("sys2_d1", 1, 1, 0, 2'd1);
    next_cycle(); Ext_Stall_IN = 1;
    expect_cyc("sys2_ext1", 1, 0, 0, 2'd1);
    next_cycle();
    expect_cyc("sys2_ext2", 1, 0, 0, 2'd1);
    next_cycle(); Ext_Stall_IN = 0;
    expect_cyc("sys2_d2", 1, 1, 0, 2'd1);
    next_cycle();
    expect_cyc("sys2_d3", 1, 1, 0, 2'd1);
    next_cycle(); Ext_Stall_IN = 1;
    expect_cyc("sys2_sig_ext", 1, 0, 0, 2'd2);
    next_cycle(); Ext_Stall_IN = 0;
    expect_cyc("sys2_sig", 1, 1, 1, 2'd2);
    next_cycle();
    expect_cyc("sys2_res", 1, 1, 0, 2'd3);
    next_cycle();
    expect_cyc("sys2_idle", 0, 0, 0, 2'd0);

    // Reset during DRAIN aborts without a SYS pulse
    next_cycle(); ins(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
    expect_cyc("sys3_issue", 0, 0, 0, 2'd0);
    next_cycle(); ins(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0, 0);
    expect_cyc("sys3_d1", 1, 1, 0, 2'd1);
    RESET = 0;
    expect_now("rst_mid", 0, 0, 0, 2'd0);
    next_cycle();
    next_cycle(); RESET = 1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      expect_cyc("post_rst", 0, 0, 0, 2'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
